// File: rtl/axi_pkg.sv
// Shared AXI3 encodings and write-responder FSM state type.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } wr_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts; purely combinational, shared by read and write responders.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int SIZE = 3,
    parameter int LENW = 4
) (
    input  logic [31:0]     addr_i,
    input  logic [SIZE-1:0] size_i,
    input  logic [LENW-1:0] len_i,
    input  logic [SIZE-2:0] burst_i,
    output logic [31:0]     addr_o
);

    logic [31:0] step;
    logic [31:0] incr;
    logic [31:0] wrap_mask;

    always_comb begin
        step      = 32'd1 << size_i;
        incr      = addr_i + step;
        wrap_mask = ((32'(len_i) + 32'd1) << size_i) - 32'd1;
        case (burst_i)
            BURST_INCR: addr_o = incr;
            // Low bits roll within the wrap window, upper bits stay put.
            BURST_WRAP: addr_o = (addr_i & ~wrap_mask) | (incr & wrap_mask);
            default:    addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_slave_write.sv
// AXI3 write responder into a byte-addressed memory: one AW, LEN+1 strobed W beats, one B.
// Handshake outputs are registered from the next state, so the three phases never overlap.
module axi_slave_write
    import axi_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int SIZE      = 3,
    parameter int MEMDEPTH  = 1024
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [DATAWIDTH/8-1:0]        AWID,
    input  logic [31:0]                   AWADDR,
    input  logic [DATAWIDTH/8-1:0]        AWLEN,
    input  logic [SIZE-1:0]               AWSIZE,
    input  logic [SIZE-2:0]               AWBURST,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [DATAWIDTH/8-1:0]        WID,
    input  logic [DATAWIDTH:0]            WDATA,
    input  logic [DATAWIDTH/8-1:0]        WSTRB,
    input  logic                          WLAST,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [DATAWIDTH/8-1:0]        BID,
    output logic [SIZE-2:0]               BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [$clog2(MEMDEPTH)-1:0]   dbg_addr,
    output logic [7:0]                    dbg_data
);

    localparam int NB = DATAWIDTH / 8;
    localparam int AW = $clog2(MEMDEPTH);

    wr_state_t       state_q, state_d;
    logic [NB-1:0]   id_q, id_d, len_q, len_d, cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d, addr_nxt;
    logic [SIZE-1:0] size_q, size_d;
    logic [SIZE-2:0] burst_q, burst_d, bresp_q, bresp_d;
    logic            err_q, err_d, sup_q, sup_d;
    logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [NB-1:0]   bid_q, bid_d;

    logic [7:0]      mem [MEMDEPTH];
    logic [31:0]     lane_addr [NB];
    logic [NB-1:0]   lane_oor, lane_we;
    logic            aw_hs, w_hs, b_hs, last_beat, aw_bad, beat_err;
    logic            unused_wdata_msb;

    assign aw_hs     = AWVALID & awready_q;
    assign w_hs      = WVALID & wready_q;
    assign b_hs      = bvalid_q & BREADY;
    assign last_beat = (cnt_q == len_q);
    assign unused_wdata_msb = WDATA[DATAWIDTH];

    // Attributes that make the whole burst unwritable are judged once, at AW time.
    assign aw_bad = (AWSIZE > SIZE'(2)) || (AWBURST == BURST_RSVD) ||
                    ((AWBURST == BURST_WRAP) && !((AWLEN == NB'(1)) || (AWLEN == NB'(3)) ||
                                                  (AWLEN == NB'(7)) || (AWLEN == NB'(15))));

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            lane_addr[i] = {addr_q[31:2], 2'b00} + 32'(i);
            lane_oor[i]  = (lane_addr[i] >= 32'(MEMDEPTH));
        end
        lane_we  = (w_hs && !sup_q) ? (WSTRB & ~lane_oor) : '0;
        beat_err = (WID != id_q) || (WLAST != last_beat) || (|(WSTRB & lane_oor));
    end

    axi_burst_addr_gen #(.SIZE(SIZE), .LENW(NB)) u_addr_gen (
        .addr_i  (addr_q),
        .size_i  (size_q),
        .len_i   (len_q),
        .burst_i (burst_q),
        .addr_o  (addr_nxt)
    );

    always_comb begin
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        sup_d   = sup_q;
        if (aw_hs) begin
            id_d    = AWID;
            addr_d  = AWADDR;
            len_d   = AWLEN;
            size_d  = AWSIZE;
            burst_d = AWBURST;
            cnt_d   = '0;
            err_d   = aw_bad;
            sup_d   = aw_bad;
        end else if (w_hs) begin
            addr_d = addr_nxt;
            cnt_d  = cnt_q + 1'b1;
            err_d  = err_q | beat_err;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (aw_hs) state_d = DATA;
            DATA:    if (w_hs && last_beat) state_d = RESP;
            RESP:    if (b_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        awready_d = (state_d == IDLE);
        wready_d  = (state_d == DATA);
        bvalid_d  = (state_d == RESP);
        bid_d     = bvalid_d ? id_d : '0;
        bresp_d   = (bvalid_d && err_d) ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            sup_q     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            sup_q     <= sup_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Memory has no reset; contents survive ARESETn.
    always_ff @(posedge ACLK) begin
        for (int i = 0; i < NB; i++) begin
            if (lane_we[i]) mem[lane_addr[i][AW-1:0]] <= WDATA[8*i +: 8];
        end
    end

    assign AWREADY  = awready_q;
    assign WREADY   = wready_q;
    assign BVALID   = bvalid_q;
    assign BID      = bid_q;
    assign BRESP    = bresp_q;
    assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_axi_slave_write.sv
// Directed bench for axi_slave_write: hand-computed bytes, responses and handshake timing.
module tb_axi_slave_write;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  AWID, AWLEN, WID, WSTRB, BID;
    logic [31:0] AWADDR;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST, BRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic [32:0] WDATA;
    logic [9:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int n_vec = 0;
    int n_err = 0;

    axi_slave_write dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [7:0] b);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int t;
        @(posedge ACLK); #1;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        t = 0;
        do begin @(negedge ACLK); t++; end while (!AWREADY && t < 50);
        if (!AWREADY) chk("aw_timeout", 32'(AWREADY), 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                          input logic last);
        int t;
        WID = id; WDATA = {1'b1, data}; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        t = 0;
        do begin @(negedge ACLK); t++; end while (!WREADY && t < 50);
        if (!WREADY) chk("w_timeout", 32'(WREADY), 1);
        @(posedge ACLK); #1;
        WVALID = 1'b0;
    endtask

    task automatic wait_b(input string tag, input logic [3:0] exp_id, input logic [1:0] exp_resp);
        int t;
        BREADY = 1'b1;
        t = 0;
        do begin @(negedge ACLK); t++; end while (!BVALID && t < 50);
        chk({tag, "_bvalid"}, 32'(BVALID), 1);
        chk({tag, "_bid"}, 32'(BID), 32'(exp_id));
        chk({tag, "_bresp"}, 32'(BRESP), 32'(exp_resp));
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        chk({tag, "_bvalid_clr"}, 32'(BVALID), 0);
        chk({tag, "_awready_back"}, 32'(AWREADY), 1);
    endtask

    task automatic rd(input string tag, input logic [9:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, 32'(dbg_data), 32'(exp));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] wrap_at [4];
        ARESETn = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
        WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; dbg_addr = '0;

        // Reset state and first-edge AWREADY
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", 32'(AWREADY), 0);
        chk("rst_wready", 32'(WREADY), 0);
        chk("rst_bvalid", 32'(BVALID), 0);
        chk("rst_bid", 32'(BID), 0);
        chk("rst_bresp", 32'(BRESP), 0);
        @(negedge ACLK); ARESETn = 1'b1;
        #1 chk("rel_awready_low", 32'(AWREADY), 0);
        @(posedge ACLK); #1;
        chk("rel_awready_high", 32'(AWREADY), 1);

        // Single INCR beat, with phase-latency checks
        send_aw(4'd5, 32'h10, 4'd0, 3'd2, 2'b01);
        chk("t1_wready_after_aw", 32'(WREADY), 1);
        chk("t1_awready_after_aw", 32'(AWREADY), 0);
        send_w(4'd5, 32'hAABBCCDD, 4'b1111, 1'b1);
        chk("t1_bvalid_next", 32'(BVALID), 1);
        chk("t1_wready_drop", 32'(WREADY), 0);
        wait_b("t1", 4'd5, 2'b00);
        rd("t1_m10", 10'h10, 8'hDD);
        rd("t1_m11", 10'h11, 8'hCC);
        rd("t1_m12", 10'h12, 8'hBB);
        rd("t1_m13", 10'h13, 8'hAA);

        // Seed words later checked as unchanged
        send_aw(4'd1, 32'h0, 4'd0, 3'd2, 2'b01);
        send_w(4'd1, 32'h01020304, 4'b1111, 1'b1);
        wait_b("seed0", 4'd1, 2'b00);
        send_aw(4'd2, 32'h3FC, 4'd0, 3'd2, 2'b01);
        send_w(4'd2, 32'hCAFEF00D, 4'b1111, 1'b1);
        wait_b("seed3fc", 4'd2, 2'b00);

        // INCR burst with a 2-cycle WVALID stall and BREADY held low
        send_aw(4'd6, 32'h20, 4'd3, 3'd2, 2'b01);
        send_w(4'd6, word_of(8'h20), 4'b1111, 1'b0);
        send_w(4'd6, word_of(8'h24), 4'b1111, 1'b0);
        for (int s = 0; s < 2; s++) begin
            chk("t2_stall_wready", 32'(WREADY), 1);
            @(posedge ACLK); #1;
        end
        send_w(4'd6, word_of(8'h28), 4'b1111, 1'b0);
        send_w(4'd6, word_of(8'h2C), 4'b1111, 1'b1);
        for (int s = 0; s < 3; s++) begin
            chk("t2_bvalid_hold", 32'(BVALID), 1);
            chk("t2_bid_hold", 32'(BID), 6);
            @(posedge ACLK); #1;
        end
        wait_b("t2", 4'd6, 2'b00);
        for (int j = 0; j < 16; j++) rd("t2_mem", 10'(32'h20 + j), 8'(32'h20 + j));

        // WRAP burst from 0x38: lands at 0x38, 0x3C, 0x30, 0x34
        send_aw(4'd9, 32'h38, 4'd3, 3'd2, 2'b10);
        for (int k = 0; k < 4; k++) send_w(4'd9, word_of(8'(8'hC0 + 4 * k)), 4'b1111, k == 3);
        wait_b("t3", 4'd9, 2'b00);
        wrap_at[0] = 10'h38; wrap_at[1] = 10'h3C; wrap_at[2] = 10'h30; wrap_at[3] = 10'h34;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) rd("t3_mem", wrap_at[k] + 10'(j), 8'(8'hC0 + 4 * k + j));

        // FIXED with complementary partial strobes
        send_aw(4'd4, 32'h40, 4'd1, 3'd2, 2'b00);
        send_w(4'd4, 32'h11223344, 4'b0101, 1'b0);
        send_w(4'd4, 32'h55667788, 4'b1010, 1'b1);
        wait_b("t4", 4'd4, 2'b00);
        rd("t4_m40", 10'h40, 8'h44);
        rd("t4_m41", 10'h41, 8'h77);
        rd("t4_m42", 10'h42, 8'h22);
        rd("t4_m43", 10'h43, 8'h55);

        // WID mismatch on beat 2: SLVERR, data still written
        send_aw(4'd3, 32'h50, 4'd3, 3'd2, 2'b01);
        for (int k = 0; k < 4; k++)
            send_w((k == 1) ? 4'd4 : 4'd3, word_of(8'(8'hA0 + 4 * k)), 4'b1111, k == 3);
        wait_b("t5", 4'd3, 2'b10);
        for (int j = 0; j < 16; j++) rd("t5_mem", 10'(32'h50 + j), 8'(32'hA0 + j));

        // Reserved burst: SLVERR, nothing written
        send_aw(4'd1, 32'h20, 4'd1, 3'd2, 2'b11);
        send_w(4'd1, 32'hDEADBEEF, 4'b1111, 1'b0);
        send_w(4'd1, 32'hDEADBEEF, 4'b1111, 1'b1);
        wait_b("t6", 4'd1, 2'b10);
        for (int j = 0; j < 8; j++) rd("t6_mem", 10'(32'h20 + j), 8'(32'h20 + j));

        // 0x3FE: upper lanes of beat 0 land, beat 1 runs past the top and is dropped
        send_aw(4'd8, 32'h3FE, 4'd1, 3'd2, 2'b01);
        send_w(4'd8, 32'h44332211, 4'b1100, 1'b0);
        send_w(4'd8, 32'h88776655, 4'b1111, 1'b1);
        wait_b("t7", 4'd8, 2'b10);
        rd("t7_m3fc", 10'h3FC, 8'h0D);
        rd("t7_m3fd", 10'h3FD, 8'hF0);
        rd("t7_m3fe", 10'h3FE, 8'h33);
        rd("t7_m3ff", 10'h3FF, 8'h44);
        rd("t7_m000", 10'h000, 8'h04);
        rd("t7_m001", 10'h001, 8'h03);

        // Reset asserted during beat 2
        send_aw(4'd2, 32'h60, 4'd3, 3'd2, 2'b01);
        send_w(4'd2, 32'h12345678, 4'b1111, 1'b0);
        WID = 4'd2; WDATA = 33'h0_9ABCDEF0; WSTRB = 4'b1111; WLAST = 1'b0; WVALID = 1'b1;
        #3 ARESETn = 1'b0;
        #1;
        chk("t8_rst_awready", 32'(AWREADY), 0);
        chk("t8_rst_wready", 32'(WREADY), 0);
        chk("t8_rst_bvalid", 32'(BVALID), 0);
        chk("t8_rst_bid", 32'(BID), 0);
        chk("t8_rst_bresp", 32'(BRESP), 0);
        WVALID = 1'b0;
        @(posedge ACLK); #2 ARESETn = 1'b1;
        #1 chk("t8_rel_awready_low", 32'(AWREADY), 0);
        @(posedge ACLK); #1;
        chk("t8_rel_awready_high", 32'(AWREADY), 1);
        send_aw(4'd7, 32'h70, 4'd0, 3'd2, 2'b01);
        send_w(4'd7, 32'h76543210, 4'b1111, 1'b1);
        wait_b("t8", 4'd7, 2'b00);
        rd("t8_m70", 10'h70, 8'h10);
        rd("t8_m73", 10'h73, 8'h76);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
